// File: rtl/si_bus_responder_pkg.sv
// Shared constants for the SiLab-style bus responder: register bank offsets
// and the start of the word-access readout region.
package si_bus_responder_pkg;

  localparam logic [3:0] OFF_VERSION = 4'd0;
  localparam logic [3:0] OFF_CONF    = 4'd1;
  localparam logic [3:0] OFF_CNT_L   = 4'd2;
  localparam logic [3:0] OFF_CNT_H   = 4'd3;
  localparam logic [3:0] OFF_OVF     = 4'd4;
  localparam logic [3:0] OFF_SCRATCH = 4'd8;

  localparam logic [31:0] WORD_REGION_BASE = 32'h8000_0000;

endpackage

// File: rtl/si_sync_fifo.sv
// Single-clock 32-bit FIFO with first-word-fall-through head and fill count.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module si_sync_fifo #(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_srst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_head,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clear;

  // Head is read combinationally so the word is available on the pop edge.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the queue like reset.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/si_bus_responder.sv
// Bus slave: 16-byte control/status bank plus a word-access window that pops
// the local data FIFO. Read data is registered and driven one cycle later.
module si_bus_responder
  import si_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] HIGHADDR   = 32'h0000_000F,
  parameter logic [7:0]  VERSION    = 8'h01,
  parameter int          FIFO_DEPTH = 512
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic [31:0] BUS_ADD,
  inout  wire  [31:0] BUS_DATA,
  input  logic        BUS_RD,
  input  logic        BUS_WR,
  output logic        BUS_BYTE_ACCESS,
  input  logic [31:0] FIFO_DATA,
  input  logic        FIFO_WRITE,
  output logic        FIFO_FULL,
  output logic [7:0]  CONF
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   w_addr_rel;
  logic          w_bank_hit;
  logic          w_word_hit;
  logic [3:0]    w_offset;
  logic          w_rd;
  logic          w_wr;
  logic          w_soft_clr;
  logic          w_pop;
  logic [31:0]   w_head;
  logic [CW-1:0] w_count;
  logic [15:0]   w_count16;
  logic          w_empty;
  logic [7:0]    w_rd_byte;
  logic          w_unused;

  logic [7:0]    r_conf;
  logic [7:0]    r_shadow;
  logic [7:0]    r_ovf;
  logic [7:0]    r_scratch [8];
  logic [31:0]   r_rd_data;
  logic          r_hit_d;

  // Relative address compare avoids a constant compare when BASEADDR is 0.
  assign w_addr_rel      = BUS_ADD - BASEADDR;
  assign w_bank_hit      = (w_addr_rel <= (HIGHADDR - BASEADDR));
  assign w_offset        = w_addr_rel[3:0];
  assign BUS_BYTE_ACCESS = (BUS_ADD < WORD_REGION_BASE);
  assign w_word_hit      = !BUS_BYTE_ACCESS && !w_bank_hit;

  // A simultaneous write strobe suppresses the read (and therefore the pop).
  assign w_rd       = BUS_RD && !BUS_WR;
  assign w_wr       = BUS_WR && w_bank_hit;
  assign w_soft_clr = w_wr && (w_offset == OFF_VERSION);
  assign w_pop      = w_rd && w_word_hit && !w_empty;
  assign w_count16  = 16'(w_count);
  assign CONF       = r_conf;
  assign w_unused   = ^BUS_DATA[31:8];

  si_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (BUS_CLK),
    .i_srst  (BUS_RST),
    .i_clear (w_soft_clr),
    .i_push  (FIFO_WRITE),
    .i_data  (FIFO_DATA),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (FIFO_FULL),
    .o_empty (w_empty)
  );

  // Configuration register write.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_conf <= '0;
    end else if (w_wr && (w_offset == OFF_CONF)) begin
      r_conf <= BUS_DATA[7:0];
    end
  end

  // Scratch bytes at offsets 8..15, one register per byte.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_scratch
      always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
          r_scratch[gi] <= '0;
        end else if (w_wr && (w_offset == (OFF_SCRATCH + 4'(gi)))) begin
          r_scratch[gi] <= BUS_DATA[7:0];
        end
      end
    end
  endgenerate

  // Overflow counter: counts dropped pushes, saturates, cleared by soft reset.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || w_soft_clr) begin
      r_ovf <= '0;
    end else if (FIFO_WRITE && FIFO_FULL && !w_pop && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  // Byte read mux for the register bank.
  always_comb begin
    w_rd_byte = 8'h00;
    case (w_offset)
      OFF_VERSION: w_rd_byte = VERSION;
      OFF_CONF:    w_rd_byte = r_conf;
      OFF_CNT_L:   w_rd_byte = w_count16[7:0];
      OFF_CNT_H:   w_rd_byte = r_shadow;
      OFF_OVF:     w_rd_byte = r_ovf;
      default: begin
        if (w_offset[3]) begin
          w_rd_byte = r_scratch[w_offset[2:0]];
        end
      end
    endcase
  end

  // Read capture: registered data, hit flag for next-cycle drive, count shadow.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_rd_data <= '0;
      r_hit_d   <= 1'b0;
      r_shadow  <= '0;
    end else begin
      r_hit_d <= w_rd && (w_bank_hit || w_word_hit);
      if (w_rd) begin
        if (w_bank_hit) begin
          r_rd_data <= {24'h0, w_rd_byte};
          if (w_offset == OFF_CNT_L) begin
            r_shadow <= w_count16[15:8];
          end
        end else if (w_word_hit) begin
          r_rd_data <= w_empty ? 32'h0 : w_head;
        end else begin
          r_rd_data <= 32'h0;
        end
      end
    end
  end

  // Drive the shared bus only in the cycle after a read hit, never during a write.
  assign BUS_DATA = (r_hit_d && !BUS_WR) ? r_rd_data : 32'bz;

endmodule
